sayuru_port_arbiter: RTL and testbench
======================================

# sayuru_port_arbiter

Two-port round-robin arbiter that shares the single core-memory-protocol slave port of the Sayuru cache (`sayuru_nway` and siblings) between two masters, e.g. the core data port (port 0) and a trace/DMA master (port 1). It accepts req/gnt/rvalid transactions from both masters and issues at most one outstanding transaction downstream. It holds the downstream request stable for that transaction's whole lifetime, because the cache re-samples its inputs on a miss, and it routes the response back to the originating master. It also counts grants per port.

## Interface
- ADDR_WIDTH, 16, address width on all ports
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 bits

- clk_i  in  1  the block's single clock
- rst_i  in  1  synchronous reset, active-high, sampled on posedge clk_i
- sN_req_i  in  1  request from master N (N = 0, 1); held high until sN_gnt_o
- sN_gnt_o  out  1  grant pulse to master N
- sN_rvalid_o  out  1  response valid to master N
- sN_addr_i  in  ADDR_WIDTH  address from master N
- sN_we_i  in  1  write enable from master N
- sN_be_i  in  DATA_WIDTH/8  byte enables from master N
- sN_wdata_i  in  DATA_WIDTH  write data from master N
- sN_rdata_o  out  DATA_WIDTH  read data to master N
- m_req_o  out  1  request to cache
- m_gnt_i  in  1  grant from cache
- m_rvalid_i  in  1  response valid from cache
- m_addr_o  out  ADDR_WIDTH  latched address to cache
- m_we_o  out  1  latched write enable to cache
- m_be_o  out  DATA_WIDTH/8  latched byte enables to cache
- m_wdata_o  out  DATA_WIDTH  latched write data to cache
- m_rdata_i  in  DATA_WIDTH  read data from cache
- grant_count0, grant_count1  out  32 (int)  grants issued per port

## Operation
- States:
  - IDLE: no transaction latched.
  - ISSUE: latched transaction presented to the cache, waiting for m_gnt_i.
  - WAIT_RVALID: granted, waiting for the response.
- IDLE behaviour:
  - If any sN_req_i is high, select a winner and latch its addr/we/be/wdata into the m_* registers.
  - Record the winner in `owner`, then go to ISSUE.
  - If no request, stay in IDLE.
- Arbitration is round-robin on `last`, the previous winner:
  - Both requesting: the port that is not `last` wins.
  - One requesting: that port wins.
  - `last` updates when the response completes.
- Combinational outputs:
  - m_req_o = (state is ISSUE or WAIT_RVALID) and not m_rvalid_i.
  - m_req_o therefore drops in the same cycle as the response, so the cache cannot see a stale request when it returns to its wait state.
- Request stability: m_addr_o, m_we_o, m_be_o and m_wdata_o are held constant from ISSUE entry until the cycle after m_rvalid_i, even if the owning master drops its req after grant.
- ISSUE: on m_gnt_i, s{owner}_gnt_o = m_gnt_i combinationally, increment grant_count{owner}, go to WAIT_RVALID.
- Grant may overlap rvalid: if m_gnt_i and m_rvalid_i are both high in ISSUE, treat it as grant plus completion and go to IDLE.
- WAIT_RVALID: on m_rvalid_i, go to IDLE and set `last` = owner.
- Response routing:
  - s{owner}_rvalid_o = m_rvalid_i and s{owner}_rdata_o = m_rdata_i, both combinationally.
  - The non-owner sees rvalid 0 and rdata 0.
- Stray handshakes: m_gnt_i or m_rvalid_i arriving in IDLE is ignored and no master output is asserted.
- Writes: the response is a plain rvalid pulse forwarded unchanged; rdata is passed through as the cache drives it (0 for writes).
- Master-side rules:
  - A master that drops req before its grant is not served if arbitration has not yet latched it.
  - Once a master is latched, its transaction completes regardless.

## Timing
- Reset values: state IDLE; `last` = 1, so port 0 wins the first tie.
- All m_* registers reset to 0; grant_count0 and grant_count1 reset to 0.
- All combinational outputs are 0 while in IDLE.
- Latency: request sampled in cycle T gives m_req_o high in T+1.
- sN_gnt_o is asserted in the same cycle as m_gnt_i.
- The earliest new arbitration is the cycle after m_rvalid_i; IDLE takes one cycle.
- Back-to-back: a master sustaining req sees at most one transaction in flight.
- Reset mid-transaction: the transaction is abandoned, all outputs return to reset values next edge, and no gnt or rvalid is delivered afterwards. The cache shares the same reset.
- Counters wrap at 2^32 (int arithmetic); no saturation.

## Test plan
- Single read, port 0:
  - Stimulus: s0 req at addr 0x0040; cache gnt after 2 cycles, rvalid with rdata 0xDEADBEEF 1 cycle later.
  - Required: s0_gnt_o pulses with m_gnt_i, s0_rvalid_o and rdata 0xDEADBEEF forwarded, s1 outputs stay 0, grant_count0 = 1.
- Simultaneous requests from reset, both masters held high for 4 transactions:
  - Required: grant order 0,1,0,1; grant_count0 = 2, grant_count1 = 2.
- Miss-style long latency:
  - Stimulus: s1 write addr 0x0100, wdata 0x12345678, be 0xF; s1 drops req after grant; rvalid arrives 12 cycles later.
  - Required: m_addr_o, m_we_o and m_wdata_o stay stable all 12 cycles; m_req_o stays high until the rvalid cycle.
- Same-cycle handshake: gnt and rvalid asserted together in ISSUE -> one gnt pulse, one rvalid pulse, return to IDLE.
- Reset mid-operation: assert rst_i in WAIT_RVALID -> all outputs 0 next cycle; a later stray m_rvalid_i produces no sN_rvalid_o.
- Stray handshakes: m_gnt_i and m_rvalid_i pulsed while IDLE -> no master output toggles, counters unchanged.

Source files
------------

// File: rtl/sayuru_port_arbiter.sv
// Two-port round-robin arbiter in front of the Sayuru cache slave port.
// One transaction in flight; the downstream request is latched and held until its response.
module sayuru_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    s0_req_i,
  output logic                    s0_gnt_o,
  output logic                    s0_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   s0_addr_i,
  input  logic                    s0_we_i,
  input  logic [DATA_WIDTH/8-1:0] s0_be_i,
  input  logic [DATA_WIDTH-1:0]   s0_wdata_i,
  output logic [DATA_WIDTH-1:0]   s0_rdata_o,
  input  logic                    s1_req_i,
  output logic                    s1_gnt_o,
  output logic                    s1_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   s1_addr_i,
  input  logic                    s1_we_i,
  input  logic [DATA_WIDTH/8-1:0] s1_be_i,
  input  logic [DATA_WIDTH-1:0]   s1_wdata_i,
  output logic [DATA_WIDTH-1:0]   s1_rdata_o,
  output logic                    m_req_o,
  input  logic                    m_gnt_i,
  input  logic                    m_rvalid_i,
  output logic [ADDR_WIDTH-1:0]   m_addr_o,
  output logic                    m_we_o,
  output logic [DATA_WIDTH/8-1:0] m_be_o,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i,
  output logic [31:0]             grant_count0,
  output logic [31:0]             grant_count1,
  output logic [1:0]              fsm_state
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ISSUE       = 2'd1,
    WAIT_RVALID = 2'd2
  } state_t;

  state_t state;
  logic   owner;
  logic   last;
  logic   pick;
  logic   gnt_fire;
  logic   resp_fire;

  assign fsm_state = state;

  // Handshake: a master holds req until it sees gnt; gnt is a one-cycle pulse
  // mirroring m_gnt_i, and rvalid/rdata arrive later as a one-cycle pulse.
  always_comb begin
    pick      = (s0_req_i && s1_req_i) ? ~last : s1_req_i;
    gnt_fire  = (state == ISSUE) && m_gnt_i;
    resp_fire = m_rvalid_i && ((state == WAIT_RVALID) || gnt_fire);
    m_req_o   = (state != IDLE) && !m_rvalid_i;
    s0_gnt_o    = 1'b0;
    s1_gnt_o    = 1'b0;
    s0_rvalid_o = 1'b0;
    s1_rvalid_o = 1'b0;
    s0_rdata_o  = '0;
    s1_rdata_o  = '0;
    if (owner) begin
      s1_gnt_o    = gnt_fire;
      s1_rvalid_o = resp_fire;
      s1_rdata_o  = resp_fire ? m_rdata_i : '0;
    end else begin
      s0_gnt_o    = gnt_fire;
      s0_rvalid_o = resp_fire;
      s0_rdata_o  = resp_fire ? m_rdata_i : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last         <= 1'b1;
      m_addr_o     <= '0;
      m_we_o       <= 1'b0;
      m_be_o       <= '0;
      m_wdata_o    <= '0;
      grant_count0 <= '0;
      grant_count1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s0_req_i || s1_req_i) begin
            owner     <= pick;
            m_addr_o  <= pick ? s1_addr_i  : s0_addr_i;
            m_we_o    <= pick ? s1_we_i    : s0_we_i;
            m_be_o    <= pick ? s1_be_i    : s0_be_i;
            m_wdata_o <= pick ? s1_wdata_i : s0_wdata_i;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_gnt_i) begin
            if (owner) grant_count1 <= grant_count1 + 32'd1;
            else       grant_count0 <= grant_count0 + 32'd1;
            // A grant that coincides with the response closes the transaction at once.
            if (m_rvalid_i) begin
              last  <= owner;
              state <= IDLE;
            end else begin
              state <= WAIT_RVALID;
            end
          end
        end
        WAIT_RVALID: begin
          if (m_rvalid_i) begin
            last  <= owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sayuru_port_arbiter.sv
// Directed bench for sayuru_port_arbiter: per-cycle vector table plus
// hand-written long-latency and reset-mid-transaction sequences.
module tb_sayuru_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_req, s0_gnt, s0_rvalid, s0_we;
  logic [15:0] s0_addr;
  logic [3:0]  s0_be;
  logic [31:0] s0_wdata, s0_rdata;
  logic        s1_req, s1_gnt, s1_rvalid, s1_we;
  logic [15:0] s1_addr;
  logic [3:0]  s1_be;
  logic [31:0] s1_wdata, s1_rdata;
  logic        m_req, m_gnt, m_rvalid, m_we;
  logic [15:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata, m_rdata;
  logic [31:0] cnt0, cnt1;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  always #5 clk = ~clk;

  sayuru_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .s0_req_i(s0_req), .s0_gnt_o(s0_gnt), .s0_rvalid_o(s0_rvalid),
    .s0_addr_i(s0_addr), .s0_we_i(s0_we), .s0_be_i(s0_be),
    .s0_wdata_i(s0_wdata), .s0_rdata_o(s0_rdata),
    .s1_req_i(s1_req), .s1_gnt_o(s1_gnt), .s1_rvalid_o(s1_rvalid),
    .s1_addr_i(s1_addr), .s1_we_i(s1_we), .s1_be_i(s1_be),
    .s1_wdata_i(s1_wdata), .s1_rdata_o(s1_rdata),
    .m_req_o(m_req), .m_gnt_i(m_gnt), .m_rvalid_i(m_rvalid),
    .m_addr_o(m_addr), .m_we_o(m_we), .m_be_o(m_be),
    .m_wdata_o(m_wdata), .m_rdata_i(m_rdata),
    .grant_count0(cnt0), .grant_count1(cnt1), .fsm_state(fsm_state)
  );

  typedef struct {
    logic        rst, r0, r1, gnt, rv;
    logic [31:0] rdata;
    logic        mreq, g0, g1, v0, v1;
    logic [31:0] d0, d1;
    logic [15:0] maddr;
    logic [31:0] c0, c1;
  } vec_t;

  vec_t vec_q[$];

  task automatic add(input logic rst_v, r0, r1, gnt, rv, input logic [31:0] rdata,
                     input logic mreq, g0, g1, v0, v1, input logic [31:0] d0, d1,
                     input logic [15:0] maddr, input logic [31:0] c0, c1);
    vec_t v;
    v.rst = rst_v; v.r0 = r0; v.r1 = r1; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.mreq = mreq; v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
    v.d0 = d0; v.d1 = d1; v.maddr = maddr; v.c0 = c0; v.c1 = c1;
    vec_q.push_back(v);
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Grant scoreboard: every master grant pulse must match the next expected port.
  always @(negedge clk) begin
    if (!rst && (s0_gnt || s1_gnt)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL grant_order: unexpected grant s0=%0d s1=%0d", s0_gnt, s1_gnt);
      end else begin
        logic [0:0] e;
        e = exp_q.pop_front();
        if ((s0_gnt && s1_gnt) || (s1_gnt != e[0])) begin
          errors++;
          $display("FAIL grant_order: got s0=%0d s1=%0d expected port %0d", s0_gnt, s1_gnt, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; s0_req = 0; s1_req = 0; m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    s0_addr = 16'h0040; s0_we = 0; s0_be = 4'hF; s0_wdata = 32'hA0A0A0A0;
    s1_addr = 16'h0200; s1_we = 0; s1_be = 4'hF; s1_wdata = 32'hB0B0B0B0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("reset_state",
          {m_req, s0_gnt, s1_gnt, s0_rvalid, s1_rvalid, s0_rdata, s1_rdata,
           m_addr, m_we, m_be, m_wdata, cnt0, cnt1, fsm_state}, '0);
    next_cycle();

    // single read on port 0
    add(0,1,0,0,0,0,            0,0,0,0,0,0,0,16'h0000,0,0);
    add(0,1,0,0,0,0,            1,0,0,0,0,0,0,16'h0040,0,0);
    add(0,1,0,0,0,0,            1,0,0,0,0,0,0,16'h0040,0,0);
    add(0,1,0,1,0,0,            1,1,0,0,0,0,0,16'h0040,0,0);
    add(0,0,0,0,1,32'hDEADBEEF, 0,0,0,1,0,32'hDEADBEEF,0,16'h0040,1,0);
    add(0,0,0,0,0,0,            0,0,0,0,0,0,0,16'h0040,1,0);
    // reset, then both masters requesting for four transactions
    add(1,0,0,0,0,0,            0,0,0,0,0,0,0,16'h0040,1,0);
    add(0,1,1,0,0,0,            0,0,0,0,0,0,0,16'h0000,0,0);
    add(0,1,1,1,0,0,            1,1,0,0,0,0,0,16'h0040,0,0);
    add(0,1,1,0,1,32'h11111111, 0,0,0,1,0,32'h11111111,0,16'h0040,1,0);
    add(0,1,1,0,0,0,            0,0,0,0,0,0,0,16'h0040,1,0);
    add(0,1,1,1,0,0,            1,0,1,0,0,0,0,16'h0200,1,0);
    add(0,1,1,0,1,32'h22222222, 0,0,0,0,1,0,32'h22222222,16'h0200,1,1);
    add(0,1,1,0,0,0,            0,0,0,0,0,0,0,16'h0200,1,1);
    add(0,1,1,1,0,0,            1,1,0,0,0,0,0,16'h0040,1,1);
    add(0,1,1,0,1,32'h33333333, 0,0,0,1,0,32'h33333333,0,16'h0040,2,1);
    add(0,1,1,0,0,0,            0,0,0,0,0,0,0,16'h0040,2,1);
    add(0,1,1,1,0,0,            1,0,1,0,0,0,0,16'h0200,2,1);
    add(0,1,1,0,1,32'h44444444, 0,0,0,0,1,0,32'h44444444,16'h0200,2,2);
    add(0,0,0,0,0,0,            0,0,0,0,0,0,0,16'h0200,2,2);
    // grant and response in the same cycle
    add(0,0,1,0,0,0,            0,0,0,0,0,0,0,16'h0200,2,2);
    add(0,0,1,1,1,32'h00000055, 0,0,1,0,1,0,32'h00000055,16'h0200,2,2);
    add(0,0,0,0,0,0,            0,0,0,0,0,0,0,16'h0200,2,3);
    // stray handshakes while idle
    add(0,0,0,1,0,0,            0,0,0,0,0,0,0,16'h0200,2,3);
    add(0,0,0,0,1,32'h0000AAAA, 0,0,0,0,0,0,0,16'h0200,2,3);
    add(0,0,0,1,1,32'h0000BBBB, 0,0,0,0,0,0,0,16'h0200,2,3);
    add(0,0,0,0,0,0,            0,0,0,0,0,0,0,16'h0200,2,3);

    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);

    for (int i = 0; i < vec_q.size(); i++) begin
      rst = vec_q[i].rst; s0_req = vec_q[i].r0; s1_req = vec_q[i].r1;
      m_gnt = vec_q[i].gnt; m_rvalid = vec_q[i].rv; m_rdata = vec_q[i].rdata;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {m_req, s0_gnt, s1_gnt, s0_rvalid, s1_rvalid, s0_rdata, s1_rdata, m_addr, cnt0, cnt1},
            {vec_q[i].mreq, vec_q[i].g0, vec_q[i].g1, vec_q[i].v0, vec_q[i].v1,
             vec_q[i].d0, vec_q[i].d1, vec_q[i].maddr, vec_q[i].c0, vec_q[i].c1});
      next_cycle();
    end
    rst = 0; s0_req = 0; s1_req = 0; m_gnt = 0; m_rvalid = 0; m_rdata = '0;

    // long-latency write on port 1; master drops req and scrambles its bus after grant
    exp_q.push_back(1'b1);
    s1_req = 1; s1_we = 1; s1_addr = 16'h0100; s1_wdata = 32'h12345678; s1_be = 4'hF;
    next_cycle();
    m_gnt = 1;
    @(negedge clk);
    check("long_gnt", {s1_gnt, s0_gnt, m_req}, {1'b1, 1'b0, 1'b1});
    next_cycle();
    m_gnt = 0; s1_req = 0; s1_we = 0; s1_addr = 16'hFFFF; s1_wdata = '0; s1_be = '0;
    for (int k = 0; k < 12; k++) begin
      m_rvalid = (k == 11);
      @(negedge clk);
      check($sformatf("long_hold%0d", k), {m_addr, m_we, m_be, m_wdata, m_req},
            {16'h0100, 1'b1, 4'hF, 32'h12345678, (k != 11)});
      if (k == 11)
        check("long_resp", {s1_rvalid, s0_rvalid, s1_rdata}, {1'b1, 1'b0, 32'h0});
      next_cycle();
    end
    m_rvalid = 0;
    @(negedge clk);
    check("long_done", {m_req, cnt0, cnt1}, {1'b0, 32'd2, 32'd4});
    next_cycle();

    // reset while waiting for the response
    exp_q.push_back(1'b0);
    s0_req = 1;
    next_cycle();
    m_gnt = 1; s0_req = 0;
    next_cycle();
    m_gnt = 0;
    @(negedge clk);
    check("rst_pre", {m_req, cnt0, m_addr}, {1'b1, 32'd3, 16'h0040});
    rst = 1;
    next_cycle();
    rst = 0;
    @(negedge clk);
    check("rst_mid",
          {m_req, s0_gnt, s1_gnt, s0_rvalid, s1_rvalid, s0_rdata, s1_rdata,
           m_addr, m_we, m_be, m_wdata, cnt0, cnt1, fsm_state}, '0);
    next_cycle();
    m_rvalid = 1; m_rdata = 32'h00000099;
    @(negedge clk);
    check("rst_stray", {m_req, s0_rvalid, s1_rvalid, s0_rdata, s1_rdata}, '0);
    next_cycle();
    m_rvalid = 0; m_rdata = '0;

    check("grant_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
